// File: rtl/spider_pkg.sv
`default_nettype none
// ============================================================================
// Package  : spider_pkg
// Brief    : Shared leg count, leg index type and leg-mask helpers for the
//            four-leg spider pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package spider_pkg;

    localparam int NLEGS = 4;

    typedef logic [1:0] leg_idx_t;

    // Index of the lowest set bit in a leg mask; 0 when the mask is empty.
    function automatic leg_idx_t lowest_leg(input logic [NLEGS-1:0] mask);
        leg_idx_t idx;
        idx = '0;
        for (int i = NLEGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = leg_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leg_event_fifo.sv
`default_nettype none
// ============================================================================
// Module   : leg_event_fifo
// Brief    : Small synchronous FIFO of leg indices. Pointers carry one extra
//            MSB so full and empty are distinguishable; a push into a full
//            FIFO is accepted when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module leg_event_fifo
    import spider_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  leg_idx_t               push_data,
    input  logic                   pop,
    output leg_idx_t               pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_PTR_ONE = (AW + 1)'(1);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    leg_idx_t    r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign full      = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty     = (r_wptr == r_rptr);
    assign level     = r_wptr - r_rptr;
    assign pop_data  = r_mem[r_rptr[AW-1:0]];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Advance read/write pointers; they wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/leg_event_collector.sv
`default_nettype none
// ============================================================================
// Module   : leg_event_collector
// Brief    : Detects rising edges on the four leg levels, holds one pending
//            bit per leg and queues at most one leg event per cycle (lowest
//            index first) into a FIFO. Losing an edge sets a sticky overflow.
//            DEPTH must be a power of two in the range 2..16.
// Revision : 1.0 - initial release
// ============================================================================
module leg_event_collector
    import spider_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   leg_right1,
    input  logic                   leg_right2,
    input  logic                   leg_right3,
    input  logic                   leg_right4,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [1:0]             ev_leg,
    output logic [$clog2(DEPTH):0] ev_level,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    logic [NLEGS-1:0] w_legs;
    logic [NLEGS-1:0] r_s;
    logic [NLEGS-1:0] r_p;
    logic             r_sampled;
    logic             r_primed;
    logic [NLEGS-1:0] r_pending;
    logic             r_overflow;

    logic [NLEGS-1:0] w_edge;
    logic [NLEGS-1:0] w_push_mask;
    logic [NLEGS-1:0] w_lost;
    logic             w_pop;
    logic             w_push;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    leg_idx_t         w_push_idx;
    leg_idx_t         w_head_leg;

    assign w_legs     = {leg_right4, leg_right3, leg_right2, leg_right1};

    // Rising edge only once primed, so legs already high at release are quiet.
    assign w_edge     = r_s & ~r_p & {NLEGS{r_primed}};

    assign w_pop      = ev_valid & ev_ready;
    assign w_push     = (|r_pending) & (~w_fifo_full | w_pop);
    assign w_push_idx = lowest_leg(r_pending);

    // One-hot of the pending bit being moved into the FIFO this cycle.
    always_comb begin
        w_push_mask = '0;
        if (w_push) begin
            w_push_mask[w_push_idx] = 1'b1;
        end
    end

    // An edge is lost when its leg is still pending and not leaving this cycle.
    assign w_lost = w_edge & r_pending & ~w_push_mask;

    // Sample the legs; primed trails the first post-reset sample by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_p       <= '0;
            r_sampled <= 1'b0;
            r_primed  <= 1'b0;
        end else begin
            r_s       <= w_legs;
            r_p       <= r_s;
            r_sampled <= 1'b1;
            r_primed  <= r_sampled;
        end
    end

    // Pending bits: cleared when pushed, set by a newly detected edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_push_mask) | w_edge;
        end
    end

    // Sticky overflow; a same-cycle loss beats the clear request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (|w_lost) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    leg_event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_idx),
        .pop       (w_pop),
        .pop_data  (w_head_leg),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .level     (ev_level)
    );

    assign ev_valid = ~w_fifo_empty;
    assign ev_leg   = w_head_leg;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_leg_event_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_leg_event_collector
// Brief    : Self-checking bench for leg_event_collector: directed scenarios
//            plus randomized traffic checked against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leg_event_collector;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    legs;
    logic          ev_ready;
    logic          clr_overflow;
    logic          ev_valid;
    logic [1:0]    ev_leg;
    logic [LW-1:0] ev_level;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    leg_event_collector #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .leg_right1   (legs[0]),
        .leg_right2   (legs[1]),
        .leg_right3   (legs[2]),
        .leg_right4   (legs[3]),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_leg       (ev_leg),
        .ev_level     (ev_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    // Reference model: leg history, pending set, event queue, sticky flag.
    bit [3:0] m_s, m_p, m_pend;
    bit       m_seen, m_primed, m_ovf;
    int       m_q[$];

    // Advance the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        bit [3:0] e;
        bit       pop, room, lost;
        int       pushed;
        if (!rst_n) begin
            m_s = '0; m_p = '0; m_pend = '0;
            m_seen = 0; m_primed = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) e[i] = m_s[i] && !m_p[i] && m_primed;
            pop  = (m_q.size() > 0) && ev_ready;
            room = (m_q.size() < DEPTH) || pop;
            pushed = -1;
            if (room) begin
                for (int i = 3; i >= 0; i--) if (m_pend[i]) pushed = i;
            end
            lost = 0;
            for (int i = 0; i < 4; i++) if (e[i] && m_pend[i] && i != pushed) lost = 1;
            if (pop) void'(m_q.pop_front());
            if (pushed >= 0) begin
                m_q.push_back(pushed);
                m_pend[pushed] = 1'b0;
            end
            m_pend = m_pend | e;
            if (lost) m_ovf = 1;
            else if (clr_overflow) m_ovf = 0;
            m_primed = m_seen;
            m_seen   = 1;
            m_p      = m_s;
            m_s      = legs;
        end
    endtask

    // One clock: update the model, then return on the falling edge to sample.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 0; legs = '0; ev_ready = 0; clr_overflow = 0;
        tick(2);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ev_valid); end
        checks++; if (ev_level !== '0) begin errors++; $display("FAIL reset_level: got %0d want 0", ev_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst_n = 1;
        tick(3);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL primed_idle_valid: got %b want 0", ev_valid); end
    endtask

    task automatic test_single_rise();
        ev_ready = 0;
        legs[2] = 1'b1;
        tick(2);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0 after 2 edges", ev_valid); end
        tick(1);
        checks++; if (ev_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1 after 3 edges", ev_valid); end
        checks++; if (ev_leg !== 2'd2) begin errors++; $display("FAIL single_leg: got %0d want 2", ev_leg); end
        checks++; if (ev_level !== LW'(1)) begin errors++; $display("FAIL single_level: got %0d want 1", ev_level); end
        tick(2);
        checks++; if (ev_valid !== 1'b1 || ev_leg !== 2'd2) begin errors++; $display("FAIL single_hold: got valid %b leg %0d want 1/2", ev_valid, ev_leg); end
        ev_ready = 1;
        tick(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_pop: got %b want 0", ev_valid); end
        ev_ready = 0; legs = '0;
        tick(3);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_fall: got %b want 0", ev_valid); end
    endtask

    task automatic test_simultaneous();
        ev_ready = 1;
        legs = 4'hF;
        tick(3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ev_valid !== 1'b1 || ev_leg !== 2'(k) || ev_level !== LW'(1)) begin
                errors++;
                $display("FAIL simul_order%0d: got valid %b leg %0d level %0d want 1/%0d/1", k, ev_valid, ev_leg, ev_level, k);
            end
            tick(1);
        end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b want 0", ev_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %b want 0", overflow); end
        legs = '0;
        tick(3);
    endtask

    task automatic test_full_fifo();
        int want_lvl[5];
        int want_leg[5];
        want_leg = '{1, 2, 3, 0, 0};
        want_lvl = '{4, 3, 2, 1, 0};
        ev_ready = 0;
        legs = 4'hF;
        tick(3);
        legs[0] = 1'b0;
        tick(1);
        legs[0] = 1'b1;
        tick(6);
        checks++; if (ev_level !== LW'(4)) begin errors++; $display("FAIL full_level: got %0d want 4", ev_level); end
        checks++; if (ev_valid !== 1'b1 || ev_leg !== 2'd0) begin errors++; $display("FAIL full_head: got valid %b leg %0d want 1/0", ev_valid, ev_leg); end
        ev_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checks++;
            if (ev_valid !== 1'b1 || ev_leg !== 2'(want_leg[k]) || ev_level !== LW'(want_lvl[k])) begin
                errors++;
                $display("FAIL full_drain%0d: got valid %b leg %0d level %0d want 1/%0d/%0d", k, ev_valid, ev_leg, ev_level, want_leg[k], want_lvl[k]);
            end
        end
        tick(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", ev_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_noloss: got %b want 0", overflow); end
        legs = '0; ev_ready = 0;
        tick(3);
    endtask

    task automatic test_overflow();
        ev_ready = 0;
        legs = 4'hF;
        tick(7);
        legs[0] = 1'b0; tick(2);
        legs[0] = 1'b1; tick(3);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_first_rise: got %b want 0", overflow); end
        legs[0] = 1'b0; tick(2);
        legs[0] = 1'b1; tick(3);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (ev_level !== LW'(4)) begin errors++; $display("FAIL ovf_level: got %0d want 4", ev_level); end
        tick(2);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        clr_overflow = 1; tick(1); clr_overflow = 0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
        ev_ready = 1; legs = '0;
        tick(8);
        checks++; if (ev_valid !== 1'b0 || ev_level !== '0) begin errors++; $display("FAIL ovf_drain: got valid %b level %0d want 0/0", ev_valid, ev_level); end
        ev_ready = 0;
    endtask

    task automatic test_reset_mid();
        ev_ready = 0;
        legs = 4'hF;
        tick(5);
        rst_n = 0;
        tick(2);
        checks++; if (ev_valid !== 1'b0 || ev_level !== '0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_clear: got valid %b level %0d ovf %b want 0/0/0", ev_valid, ev_level, overflow); end
        rst_n = 1;
        tick(6);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL midrst_high_legs: got %b want 0", ev_valid); end
        legs[1] = 1'b0; tick(2);
        legs[1] = 1'b1; tick(3);
        checks++; if (ev_valid !== 1'b1 || ev_leg !== 2'd1 || ev_level !== LW'(1)) begin errors++; $display("FAIL midrst_rise: got valid %b leg %0d level %0d want 1/1/1", ev_valid, ev_leg, ev_level); end
        ev_ready = 1; tick(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL midrst_pop: got %b want 0", ev_valid); end
        legs = '0; ev_ready = 0;
        tick(3);
    endtask

    task automatic test_random();
        int ready_pct;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) ready_pct = $urandom_range(10, 95);
            rst_n        = ($urandom_range(0, 299) != 0);
            ev_ready     = ($urandom_range(0, 99) < ready_pct);
            clr_overflow = ($urandom_range(0, 11) == 0);
            for (int i = 0; i < 4; i++) if ($urandom_range(0, 5) == 0) legs[i] = ~legs[i];
            tick(1);
            checks++;
            if (ev_valid !== (m_q.size() > 0) || ev_level !== LW'(m_q.size()) || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand_state c%0d: got valid %b level %0d ovf %b want %b/%0d/%b", c, ev_valid, ev_level, overflow, (m_q.size() > 0), m_q.size(), m_ovf);
            end
            if (m_q.size() > 0) begin
                checks++;
                if (ev_leg !== 2'(m_q[0])) begin
                    errors++;
                    $display("FAIL rand_leg c%0d: got %0d want %0d", c, ev_leg, m_q[0]);
                end
            end
        end
        rst_n = 1; clr_overflow = 0; ev_ready = 0;
    endtask

    initial begin
        rst_n = 0; legs = '0; ev_ready = 0; clr_overflow = 0;
        test_reset();
        test_single_rise();
        test_simultaneous();
        test_full_fifo();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
